instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage that keeps one instruction-cache read outstanding and registers results into if_id.
// Ports:
//   clk, rst (async, active-low)   pipeline clock and reset
//   stall                          downstream backpressure; if_id holds while 1
//   ctrl_hazard, br_pc             redirect request and its target
//   redirect_order                 order value given to the first instruction after a redirect
//   imem_address, imem_read        cache request (address is stable until imem_resp)
//   imem_rdata, imem_resp          cache response data and one-cycle response pulse
//   if_id [193:0]                  {valid, ir, pc_out, pcmux_out, br_taken, br_pc, order[63:0]}
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h40000060
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         ctrl_hazard,
  input  logic [31:0]  br_pc,
  input  logic [63:0]  redirect_order,
  output logic [31:0]  imem_address,
  output logic         imem_read,
  input  logic [31:0]  imem_rdata,
  input  logic         imem_resp,
  output logic [193:0] if_id
);
  localparam logic [193:0] NOP = {1'b0, 32'h00000013, 161'b0};
  typedef enum logic [1:0] {REQ, HOLD, DRAIN} state_t;
  state_t        r_state, w_state;
  logic [31:0]   r_pc, w_pc, r_req, w_req, w_next;
  logic [63:0]   r_order, w_order;
  logic [193:0]  r_skid, w_skid, r_if_id, w_if_id, w_pkt;
  assign w_next       = r_req + 32'd4;
  assign w_pkt        = {1'b1, imem_rdata, r_req, w_next, 1'b0, w_next, r_order};
  // Gated by rst so no request is visible while reset is held.
  assign imem_read    = rst && (r_state != HOLD);
  assign imem_address = r_req;
  assign if_id        = r_if_id;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_req   = r_req;
    w_order = r_order;
    w_skid  = r_skid;
    w_if_id = r_if_id;
    if (ctrl_hazard) begin
      w_if_id = NOP;
      w_skid  = '0;
      w_pc    = br_pc;
      w_order = redirect_order;
      case (r_state)
        // A read still in flight must be drained before the target can be requested.
        REQ:     begin w_state = imem_resp ? REQ : DRAIN; w_req = imem_resp ? br_pc : r_req; end
        HOLD:    begin w_state = REQ; w_req = br_pc; end
        default: begin w_state = imem_resp ? REQ : DRAIN; w_req = imem_resp ? br_pc : r_req; end
      endcase
    end else begin
      case (r_state)
        REQ: if (imem_resp) begin
          w_pc    = w_next;
          w_req   = w_next;
          w_order = r_order + 64'd1;
          w_skid  = stall ? w_pkt : r_skid;
          w_if_id = stall ? r_if_id : w_pkt;
          w_state = stall ? HOLD : REQ;
        end
        HOLD: if (!stall) begin
          w_if_id = r_skid;
          w_skid  = '0;
          w_req   = r_pc;
          w_state = REQ;
        end
        default: if (imem_resp) begin
          w_req   = r_pc;
          w_state = REQ;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_req   <= RESET_PC;
      r_order <= '0;
      r_skid  <= '0;
      r_if_id <= NOP;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_req   <= w_req;
      r_order <= w_order;
      r_skid  <= w_skid;
      r_if_id <= w_if_id;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: table-driven directed bench for instruction_fetch.
module tb_instruction_fetch;
  logic         clk = 0, rst = 0, stall = 0, ctrl_hazard = 0, imem_resp = 0, imem_read;
  logic [31:0]  br_pc = 0, imem_rdata = 0, imem_address;
  logic [63:0]  redirect_order = 0;
  logic [193:0] if_id;
  logic         resp2 = 0, read2;
  logic [31:0]  rd2 = 0, addr2;
  logic [193:0] if_id2;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  instruction_fetch u_dut (
    .clk(clk), .rst(rst), .stall(stall), .ctrl_hazard(ctrl_hazard), .br_pc(br_pc),
    .redirect_order(redirect_order), .imem_address(imem_address), .imem_read(imem_read),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp), .if_id(if_id)
  );
  instruction_fetch #(.RESET_PC(32'hFFFFFFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .ctrl_hazard(1'b0), .br_pc(32'h0),
    .redirect_order(64'h0), .imem_address(addr2), .imem_read(read2),
    .imem_rdata(rd2), .imem_resp(resp2), .if_id(if_id2)
  );
  typedef struct {
    logic st, hz; logic [31:0] br; logic [63:0] ro; logic rsp;
    logic er; logic [31:0] ea; logic ev; logic [31:0] epc; logic [63:0] eo;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic st, logic hz, logic [31:0] br, logic [63:0] ro, logic rsp,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] epc, logic [63:0] eo);
    vec_t v;
    v.st = st; v.hz = hz; v.br = br; v.ro = ro; v.rsp = rsp;
    v.er = er; v.ea = ea; v.ev = ev; v.epc = epc; v.eo = eo;
    return v;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // Instruction data is ~address, so ir of a valid entry is derived from its pc.
  task automatic chk_ifid(input string n, input logic [193:0] id, input logic ev,
                          input logic [31:0] epc, input logic [63:0] eo);
    logic [31:0] eir, emux, epcv;
    eir  = ev ? ~epc : 32'h00000013;
    emux = ev ? epc + 32'd4 : 32'd0;
    epcv = ev ? epc : 32'd0;
    chk({n, ".valid"}, {63'd0, id[193]}, {63'd0, ev});
    chk({n, ".ir"}, {32'd0, id[192:161]}, {32'd0, eir});
    chk({n, ".pc_out"}, {32'd0, id[160:129]}, {32'd0, epcv});
    chk({n, ".pcmux_out"}, {32'd0, id[128:97]}, {32'd0, emux});
    chk({n, ".br_taken"}, {63'd0, id[96]}, 64'd0);
    chk({n, ".br_pc"}, {32'd0, id[95:64]}, {32'd0, emux});
    chk({n, ".order"}, id[63:0], ev ? eo : 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    //                st hz br            ro                     rsp er ea            ev epc           eo
    tbl.push_back(mk(0, 0, 0,            0,                     0, 1, 32'h40000060, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000060, 1, 32'h40000060, 0));
    tbl.push_back(mk(0, 0, 0,            0,                     0, 1, 32'h40000064, 1, 32'h40000060, 0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000064, 1, 32'h40000064, 1));
    tbl.push_back(mk(0, 0, 0,            0,                     0, 1, 32'h40000068, 1, 32'h40000064, 1));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000068, 1, 32'h40000068, 2));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h4000006C, 1, 32'h4000006C, 3));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000070, 1, 32'h40000070, 4));
    tbl.push_back(mk(1, 0, 0,            0,                     1, 1, 32'h40000074, 1, 32'h40000070, 4));
    tbl.push_back(mk(1, 0, 0,            0,                     0, 0, 0,            1, 32'h40000070, 4));
    tbl.push_back(mk(1, 0, 0,            0,                     0, 0, 0,            1, 32'h40000070, 4));
    tbl.push_back(mk(0, 0, 0,            0,                     0, 0, 0,            1, 32'h40000074, 5));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000078, 1, 32'h40000078, 6));
    tbl.push_back(mk(0, 1, 32'h40000100, 7,                     0, 1, 32'h4000007C, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     0, 1, 32'h4000007C, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h4000007C, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000100, 1, 32'h40000100, 7));
    tbl.push_back(mk(1, 1, 32'h40000200, 64'hFFFFFFFFFFFFFFFF,  1, 1, 32'h40000104, 0, 0,            0));
    tbl.push_back(mk(1, 0, 0,            0,                     1, 1, 32'h40000200, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     0, 0, 0,            1, 32'h40000200, 64'hFFFFFFFFFFFFFFFF));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000204, 1, 32'h40000204, 0));
    tbl.push_back(mk(1, 0, 0,            0,                     1, 1, 32'h40000208, 1, 32'h40000204, 0));
    tbl.push_back(mk(1, 1, 32'h40000300, 64'h20,                0, 0, 0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     0, 1, 32'h40000300, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000300, 1, 32'h40000300, 64'h20));
    tbl.push_back(mk(0, 1, 32'h40000400, 64'h30,                0, 1, 32'h40000304, 0, 0,            0));
    tbl.push_back(mk(0, 1, 32'h40000500, 64'h40,                0, 1, 32'h40000304, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000304, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000500, 1, 32'h40000500, 64'h40));
    tbl.push_back(mk(0, 1, 32'h40000600, 64'h50,                0, 1, 32'h40000504, 0, 0,            0));
    tbl.push_back(mk(0, 1, 32'h40000700, 64'h60,                1, 1, 32'h40000504, 0, 0,            0));
    tbl.push_back(mk(0, 0, 0,            0,                     1, 1, 32'h40000700, 1, 32'h40000700, 64'h60));
    repeat (2) @(posedge clk);
    #1;
    chk("reset.imem_read", {63'd0, imem_read}, 64'd0);
    chk("reset.imem_read2", {63'd0, read2}, 64'd0);
    chk_ifid("reset", if_id, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].st;
      ctrl_hazard = tbl[i].hz;
      br_pc = tbl[i].br;
      redirect_order = tbl[i].ro;
      imem_resp = tbl[i].rsp;
      imem_rdata = ~tbl[i].ea;
      #1;
      chk($sformatf("v%0d.imem_read", i), {63'd0, imem_read}, {63'd0, tbl[i].er});
      if (tbl[i].er) chk($sformatf("v%0d.imem_address", i), {32'd0, imem_address}, {32'd0, tbl[i].ea});
      @(posedge clk);
      #1;
      chk_ifid($sformatf("v%0d", i), if_id, tbl[i].ev, tbl[i].epc, tbl[i].eo);
      @(negedge clk);
    end
    ctrl_hazard = 1; br_pc = 32'h40000800; redirect_order = 5; imem_resp = 0; stall = 0;
    @(posedge clk);
    @(negedge clk);
    ctrl_hazard = 0;
    #1;
    chk("drain.imem_read", {63'd0, imem_read}, 64'd1);
    chk("drain.imem_address", {32'd0, imem_address}, 64'h40000704);
    #1 rst = 0;
    #1;
    chk("async_rst.imem_read", {63'd0, imem_read}, 64'd0);
    chk("async_rst.imem_address", {32'd0, imem_address}, 64'h40000060);
    chk_ifid("async_rst", if_id, 0, 0, 0);
    @(negedge clk);
    rst = 1;
    imem_resp = 1;
    imem_rdata = ~32'h40000060;
    #1;
    chk("post_rst.imem_read", {63'd0, imem_read}, 64'd1);
    chk("post_rst.imem_address", {32'd0, imem_address}, 64'h40000060);
    @(posedge clk);
    #1;
    chk_ifid("post_rst", if_id, 1, 32'h40000060, 0);
    @(negedge clk);
    imem_resp = 0;
    resp2 = 1;
    rd2 = ~32'hFFFFFFFC;
    #1;
    chk("wrap.addr0", {32'd0, addr2}, 64'hFFFFFFFC);
    @(posedge clk);
    #1;
    chk_ifid("wrap0", if_id2, 1, 32'hFFFFFFFC, 0);
    chk("wrap.addr1", {32'd0, addr2}, 64'h0);
    @(negedge clk);
    rd2 = ~32'h0;
    @(posedge clk);
    #1;
    chk_ifid("wrap1", if_id2, 1, 32'h0, 1);
    @(negedge clk);
    resp2 = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
